// File: rtl/fetch_pred_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer and its
// in-flight prediction queue.
package fetch_pred_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int BHT_IDX_W  = 4;
  localparam int BHT_IDX_LO = 2;
  localparam int BHT_IDX_HI = BHT_IDX_LO + BHT_IDX_W - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } pred_entry_t;

  function automatic logic [BHT_IDX_W-1:0] bht_index(input logic [31:0] addr);
    return addr[BHT_IDX_HI:BHT_IDX_LO];
  endfunction

endpackage

// File: rtl/fetch_pred_ctrl_pred_queue.sv
// In-order circular FIFO of fetch predictions awaiting resolution in EX.
// clear_i wins over push/pop so a flush leaves the queue empty.
module pred_queue
  import fetch_pred_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  pred_entry_t entry_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pred_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    rd_d  = do_pop  ? next_ptr(rd_q) : rd_q;
    wr_d  = do_push ? next_ptr(wr_q) : wr_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_pred_ctrl.sv
// Fetch PC sequencer: BHT/BTB lookup, next-PC selection, in-order prediction
// tracking and mispredict redirect with BHT update on branch resolution.
module fetch_pred_ctrl
  import fetch_pred_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        bht_taken,
  input  logic [31:0] bht_btp,
  output logic [3:0]  bht_ind,
  output logic        bht_br,
  output logic        bht_val,
  output logic [31:0] bht_bta,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic        ex_taken,
  input  logic [31:0] ex_target
);

  logic [31:0] pc_q, pc_d;
  logic        started_q;
  pred_entry_t head, push_entry;
  logic        q_full, q_empty;
  logic        resolve, upd, act_taken, mispred, issue;

  assign resolve   = ex_valid & ~q_empty;
  assign upd       = resolve & ex_is_br;
  assign act_taken = ex_is_br & ex_taken;
  // A non-branch with pred=1 falls out of the direction compare (BTB alias).
  assign mispred   = resolve & ((head.pred != act_taken) |
                                (head.pred & act_taken & (head.tgt != ex_target)));

  assign pc_valid  = started_q & ~q_full & ~upd & ~mispred;
  assign issue     = pc_valid & ~stall;
  assign flush     = mispred;
  assign pc        = pc_q;

  assign bht_br    = upd;
  assign bht_ind   = upd ? bht_index(head.pc) : bht_index(pc_q);
  assign bht_val   = upd & ex_taken;
  assign bht_bta   = upd ? ex_target : 32'h0;

  assign push_entry = '{pc: pc_q, pred: bht_taken, tgt: bht_btp};

  always_comb begin
    pc_d = pc_q;
    if (mispred)    pc_d = act_taken ? ex_target : head.pc + 32'd4;
    else if (issue) pc_d = bht_taken ? bht_btp : pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
    end
  end

  pred_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue),
    .pop_i   (resolve),
    .clear_i (mispred),
    .entry_i (push_entry),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // A resolve with nothing in flight means EX and fetch have lost sync.
  always @(posedge clk) begin
    if (rst_n) assert (!(ex_valid && q_empty));
  end

endmodule

// File: tb/tb_fetch_pred_ctrl.sv
// Directed and randomized bench for fetch_pred_ctrl against a queue-based model.
module tb_fetch_pred_ctrl;

  localparam int          QD   = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        bht_taken = 1'b0;
  logic [31:0] bht_btp = 32'h0;
  logic [3:0]  bht_ind;
  logic        bht_br, bht_val, pc_valid, flush;
  logic [31:0] bht_bta, pc;
  logic        ex_valid = 1'b0;
  logic        ex_is_br = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;

  always #5 clk = ~clk;

  fetch_pred_ctrl #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .bht_taken (bht_taken),
    .bht_btp   (bht_btp),
    .bht_ind   (bht_ind),
    .bht_br    (bht_br),
    .bht_val   (bht_val),
    .bht_bta   (bht_bta),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_is_br  (ex_is_br),
    .ex_taken  (ex_taken),
    .ex_target (ex_target)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = RPC;
  bit          m_started = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs for this cycle, then the state the fetch unit should hold after the edge.
  task automatic model_check();
    bit          res, act, mis, upd, v;
    ent_t        h;
    logic [31:0] e_ind;
    h   = '{pc: 32'h0, pred: 1'b0, tgt: 32'h0};
    res = ex_valid && (mq.size() > 0);
    if (mq.size() > 0) h = mq[0];
    act = ex_is_br && ex_taken;
    mis = res && ((h.pred != act) || (h.pred && act && (h.tgt != ex_target)));
    upd = res && ex_is_br;
    v   = rst_n && m_started && (mq.size() < QD) && !upd && !mis;
    e_ind = upd ? 32'(h.pc[5:2]) : 32'(m_pc[5:2]);
    chk("pc",       pc,              m_pc);
    chk("pc_valid", 32'(pc_valid),   32'(v));
    chk("flush",    32'(flush),      32'(mis));
    chk("bht_br",   32'(bht_br),     32'(upd));
    chk("bht_ind",  32'(bht_ind),    e_ind);
    chk("bht_val",  32'(bht_val),    upd ? 32'(ex_taken) : 32'h0);
    chk("bht_bta",  bht_bta,         upd ? ex_target : 32'h0);
    if (rst_n) begin
      if (mis) begin
        mq.delete();
        m_pc = act ? ex_target : h.pc + 32'd4;
      end else begin
        if (res) void'(mq.pop_front());
        if (v && !stall) begin
          mq.push_back('{pc: m_pc, pred: bht_taken, tgt: bht_btp});
          m_pc = bht_taken ? bht_btp : m_pc + 32'd4;
        end
      end
      m_started = 1'b1;
    end
  endtask

  task automatic drive(input bit s, input bit bt, input logic [31:0] bb,
                       input bit ev, input bit eb, input bit et, input logic [31:0] etg);
    stall = s; bht_taken = bt; bht_btp = bb;
    ex_valid = ev; ex_is_br = eb; ex_taken = et; ex_target = etg;
  endtask

  task automatic sample();
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tg;
    bit          ev;
    @(negedge clk);
    // Held in reset
    drive(0, 0, 0, 0, 0, 0, 0);
    sample(); tick();
    sample();
    chk("rst_pc", pc, RPC);
    chk("rst_pc_valid", 32'(pc_valid), 32'h0);
    chk("rst_bht_br", 32'(bht_br), 32'h0);
    tick();
    rst_n = 1'b1;
    sample(); tick();
    // Fill with not-taken predictions, no resolves
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("fill_pc", pc, 32'(i * 4));
      tick();
    end
    // Full: resolve 0x0 as correct non-branch
    drive(0, 0, 0, 1, 0, 0, 0);
    sample();
    chk("full_pc", pc, 32'h10);
    chk("full_bubble", 32'(pc_valid), 32'h0);
    tick();
    // Taken prediction at 0x10 -> 0x80 while 0x4 resolves
    drive(0, 1, 32'h80, 1, 0, 0, 0);
    sample();
    chk("pred_valid", 32'(pc_valid), 32'h1);
    tick();
    chk("pred_next_pc", pc, 32'h80);
    // Head 0x8 (pred 0) resolves taken to 0x40
    drive(0, 0, 0, 1, 1, 1, 32'h40);
    sample();
    chk("mp_flush", 32'(flush), 32'h1);
    chk("mp_bht_ind", 32'(bht_ind), 32'h2);
    chk("mp_bht_bta", bht_bta, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("mp_redirect_pc", pc, 32'h40);
    chk("mp_after_valid", 32'(pc_valid), 32'h1);
    tick();
    // Correct not-taken branch at 0x40
    drive(0, 0, 0, 1, 1, 0, 32'h0);
    sample();
    chk("nt_bht_br", 32'(bht_br), 32'h1);
    chk("nt_flush", 32'(flush), 32'h0);
    chk("nt_bubble", 32'(pc_valid), 32'h0);
    tick();
    chk("nt_pc_held", pc, 32'h44);
    // 0x44 predicts taken to 0x20, 0x20 predicts taken to 0x100
    drive(0, 1, 32'h20, 0, 0, 0, 0);
    sample(); tick();
    drive(0, 1, 32'h100, 0, 0, 0, 0);
    sample(); tick();
    chk("alias_setup_pc", pc, 32'h100);
    drive(0, 0, 0, 1, 1, 1, 32'h20);
    sample();
    chk("tk_ok_flush", 32'(flush), 32'h0);
    chk("tk_ok_bht_br", 32'(bht_br), 32'h1);
    tick();
    // Non-branch at 0x20 with pred=1
    drive(0, 0, 0, 1, 0, 0, 0);
    sample();
    chk("alias_flush", 32'(flush), 32'h1);
    chk("alias_bht_br", 32'(bht_br), 32'h0);
    tick();
    chk("alias_pc", pc, 32'h24);
    // Queue three entries then reset mid-operation
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample(); tick();
    end
    mq.delete(); m_pc = RPC; m_started = 1'b0;
    rst_n = 1'b0;
    sample();
    chk("mid_rst_pc", pc, RPC);
    chk("mid_rst_bht_br", 32'(bht_br), 32'h0);
    tick();
    rst_n = 1'b1;
    sample(); tick();
    for (int i = 0; i < 5; i++) begin
      sample(); tick();
    end
    chk("post_rst_fill_pc", pc, 32'h10);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ev = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
      tg = ((mq.size() > 0) && ($urandom_range(0, 1) == 1)) ? mq[0].tgt : ($urandom & 32'h0000_00FC);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, $urandom & 32'h0000_00FC,
            ev, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, tg);
      sample(); tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
